// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the multi-alarm clock.
// The ST_SNOOZE state exists only when CLOCK_SNOOZE_EN is defined.
package clock_pkg;

    localparam logic [7:0] MAX_HH = 8'd23;
    localparam logic [7:0] MAX_MS = 8'd59;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hh_t;
        bcd_digit_t hh_u;
        bcd_digit_t mm_t;
        bcd_digit_t mm_u;
        bcd_digit_t ss_t;
        bcd_digit_t ss_u;
    } bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1
`ifdef CLOCK_SNOOZE_EN
        ,
        ST_SNOOZE = 2'd2
`endif
    } state_t;

    function automatic logic [7:0] bcd_pair_bin(input bcd_digit_t tens, input bcd_digit_t units);
        return 8'(tens) * 8'd10 + 8'(units);
    endfunction

    function automatic logic bcd_pair_legal(input bcd_digit_t tens, input bcd_digit_t units,
                                            input logic [7:0] max_val);
        return (units <= 4'd9) && (bcd_pair_bin(tens, units) <= max_val);
    endfunction

    // Two-digit BCD increment that wraps to 00 after max_val; bit 8 is the carry out.
    function automatic logic [8:0] bcd_pair_inc(input bcd_digit_t tens, input bcd_digit_t units,
                                                input logic [7:0] max_val);
        logic [8:0] res;
        if (bcd_pair_bin(tens, units) == max_val) begin
            res = {1'b1, 8'h00};
        end else if (units == 4'd9) begin
            res = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            res = {1'b0, tens, units + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Seconds prescaler plus 24-hour BCD time-of-day register with a validated load.
// time_upd flags the cycle right after any time change (increment or load).
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned M_FREQ = 20_000_000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        load_time,
    input  logic [23:0] load_bcd,
    output logic [23:0] bcd_time,
    output logic        sec_pulse,
    output logic        time_upd
);

    localparam logic [31:0] PRESC_LAST = 32'(M_FREQ - 1);

    logic [31:0] presc_q, presc_d;
    bcd_time_t   time_q, time_d;
    logic        upd_q, upd_d;

    bcd_time_t   load_v;
    bcd_time_t   inc_v;
    logic        load_ok;
    logic [8:0]  ss_inc, mm_inc, hh_inc;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        load_v  = bcd_time_t'(load_bcd);
        load_ok = load_time
               && bcd_pair_legal(load_v.hh_t, load_v.hh_u, MAX_HH)
               && bcd_pair_legal(load_v.mm_t, load_v.mm_u, MAX_MS)
               && bcd_pair_legal(load_v.ss_t, load_v.ss_u, MAX_MS);

        ss_inc = bcd_pair_inc(time_q.ss_t, time_q.ss_u, MAX_MS);
        mm_inc = bcd_pair_inc(time_q.mm_t, time_q.mm_u, MAX_MS);
        hh_inc = bcd_pair_inc(time_q.hh_t, time_q.hh_u, MAX_HH);

        inc_v = time_q;
        {inc_v.ss_t, inc_v.ss_u} = ss_inc[7:0];
        if (ss_inc[8]) begin
            {inc_v.mm_t, inc_v.mm_u} = mm_inc[7:0];
            if (mm_inc[8]) begin
                {inc_v.hh_t, inc_v.hh_u} = hh_inc[7:0];
            end
        end

        sec_pulse = (presc_q == PRESC_LAST);
        presc_d   = sec_pulse ? '0 : presc_q + 32'd1;
        time_d    = time_q;
        upd_d     = 1'b0;

        // A legal load wins over a coinciding second tick and restarts the second.
        if (load_ok) begin
            time_d  = load_v;
            presc_d = '0;
            upd_d   = 1'b1;
        end else if (sec_pulse) begin
            time_d  = inc_v;
            upd_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            time_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
            upd_q   <= upd_d;
        end
    end

    assign bcd_time = time_q;
    assign time_upd = upd_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// Time-of-day clock with N alarm slots and a ring/snooze FSM driving the buzzer.
// Define CLOCK_SNOOZE_EN to build the SNOOZE state; otherwise the snooze input is ignored.
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter  int unsigned M_FREQ      = 20_000_000,
    parameter  int unsigned N_ALARMS    = 4,
    parameter  int unsigned RING_SECS   = 5,
    parameter  int unsigned SNOOZE_SECS = 300,
    localparam int          IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                load_time,
    input  logic [23:0]         load_bcd,
    input  logic                alarm_wr,
    input  logic [IDX_W-1:0]    alarm_idx,
    input  logic [15:0]         alarm_bcd,
    input  logic                alarm_en_in,
    input  logic                snooze,
    input  logic                stop,
    output logic [23:0]         bcd_time,
    output logic                sec_pulse,
    output logic                buzzer,
    output logic [IDX_W-1:0]    ring_idx,
    output logic [N_ALARMS-1:0] alarm_armed
);

    localparam logic [7:0] RING_INIT = 8'(RING_SECS);

    logic time_upd;

    bcd_time_counter #(
        .M_FREQ (M_FREQ)
    ) u_time (
        .mclk      (mclk),
        .rst       (rst),
        .load_time (load_time),
        .load_bcd  (load_bcd),
        .bcd_time  (bcd_time),
        .sec_pulse (sec_pulse),
        .time_upd  (time_upd)
    );

    // ---------------- alarm bank ----------------
    logic [15:0]         alarm_hhmm_q [N_ALARMS];
    logic [15:0]         alarm_hhmm_d [N_ALARMS];
    logic [N_ALARMS-1:0] alarm_en_q, alarm_en_d;
    logic                wr_ok;

    always_comb begin
        wr_ok = alarm_wr
             && (32'(alarm_idx) < N_ALARMS)
             && bcd_pair_legal(alarm_bcd[15:12], alarm_bcd[11:8], MAX_HH)
             && bcd_pair_legal(alarm_bcd[7:4],   alarm_bcd[3:0],  MAX_MS);
        alarm_hhmm_d = alarm_hhmm_q;
        alarm_en_d   = alarm_en_q;
        for (int i = 0; i < int'(N_ALARMS); i++) begin
            if (wr_ok && (alarm_idx == IDX_W'(i))) begin
                alarm_hhmm_d[i] = alarm_bcd;
                alarm_en_d[i]   = alarm_en_in;
            end
        end
    end

    // NOTE: the slot array is small and must read 00:00/disabled after reset, so it is reset like any flop.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_ALARMS); i++) begin
                alarm_hhmm_q[i] <= '0;
            end
            alarm_en_q <= '0;
        end else begin
            alarm_hhmm_q <= alarm_hhmm_d;
            alarm_en_q   <= alarm_en_d;
        end
    end

    assign alarm_armed = alarm_en_q;

    // Scan from the top so the lowest matching slot is the one left standing.
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;

    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
            if (alarm_en_q[i] && (alarm_hhmm_q[i] == bcd_time[23:8])) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
        if (!(time_upd && (bcd_time[7:0] == 8'h00))) begin
            match_hit = 1'b0;
        end
    end

    // ---------------- ring / snooze FSM ----------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ring_idx_q, ring_idx_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d;
    logic             ring_slot_wr;

    assign ring_slot_wr = wr_ok && (alarm_idx == ring_idx_q);

`ifdef CLOCK_SNOOZE_EN
    localparam logic [11:0] SNOOZE_INIT = 12'(SNOOZE_SECS);
    logic [11:0] snooze_cnt_q, snooze_cnt_d;
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    always_comb begin
        state_d    = state_q;
        ring_idx_d = ring_idx_q;
        ring_cnt_d = ring_cnt_q;
`ifdef CLOCK_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (match_hit) begin
                    state_d    = ST_RING;
                    ring_idx_d = match_idx;
                    ring_cnt_d = RING_INIT;
                end
            end
            ST_RING: begin
                if (ring_slot_wr || stop) begin
                    state_d = ST_IDLE;
`ifdef CLOCK_SNOOZE_EN
                end else if (snooze) begin
                    state_d      = ST_SNOOZE;
                    snooze_cnt_d = SNOOZE_INIT;
`endif
                end else if (sec_pulse) begin
                    ring_cnt_d = ring_cnt_q - 8'd1;
                    if (ring_cnt_q <= 8'd1) begin
                        state_d    = ST_IDLE;
                        ring_cnt_d = '0;
                    end
                end
            end
`ifdef CLOCK_SNOOZE_EN
            ST_SNOOZE: begin
                if (ring_slot_wr || stop) begin
                    state_d = ST_IDLE;
                end else if (sec_pulse) begin
                    snooze_cnt_d = snooze_cnt_q - 12'd1;
                    if (snooze_cnt_q <= 12'd1) begin
                        state_d      = ST_RING;
                        snooze_cnt_d = '0;
                        ring_cnt_d   = RING_INIT;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_idx_q <= '0;
            ring_cnt_q <= '0;
`ifdef CLOCK_SNOOZE_EN
            snooze_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ring_idx_q <= ring_idx_d;
            ring_cnt_q <= ring_cnt_d;
`ifdef CLOCK_SNOOZE_EN
            snooze_cnt_q <= snooze_cnt_d;
`endif
        end
    end

    // Decoded straight from the async-reset state flop so reset silences it without a clock.
    assign buzzer   = (state_q == ST_RING);
    assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed self-checking bench for multi_alarm_clock (M_FREQ=4, RING=3 s, SNOOZE=5 s, 4 slots).
module tb_multi_alarm_clock;

    localparam int unsigned M_FREQ      = 4;
    localparam int unsigned N_ALARMS    = 4;
    localparam int unsigned RING_SECS   = 3;
    localparam int unsigned SNOOZE_SECS = 5;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        load_time = 1'b0;
    logic [23:0] load_bcd = '0;
    logic        alarm_wr = 1'b0;
    logic [1:0]  alarm_idx = '0;
    logic [15:0] alarm_bcd = '0;
    logic        alarm_en_in = 1'b0;
    logic        snooze = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] bcd_time;
    logic        sec_pulse;
    logic        buzzer;
    logic [1:0]  ring_idx;
    logic [3:0]  alarm_armed;

    int n_checks = 0;
    int n_pass   = 0;

    multi_alarm_clock #(
        .M_FREQ      (M_FREQ),
        .N_ALARMS    (N_ALARMS),
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .load_time   (load_time),
        .load_bcd    (load_bcd),
        .alarm_wr    (alarm_wr),
        .alarm_idx   (alarm_idx),
        .alarm_bcd   (alarm_bcd),
        .alarm_en_in (alarm_en_in),
        .snooze      (snooze),
        .stop        (stop),
        .bcd_time    (bcd_time),
        .sec_pulse   (sec_pulse),
        .buzzer      (buzzer),
        .ring_idx    (ring_idx),
        .alarm_armed (alarm_armed)
    );

    always #5 mclk = ~mclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        load_time = 1'b1;
        load_bcd  = v;
        tick();
        load_time = 1'b0;
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [15:0] hhmm, input logic en);
        alarm_wr    = 1'b1;
        alarm_idx   = idx;
        alarm_bcd   = hhmm;
        alarm_en_in = en;
        tick();
        alarm_wr    = 1'b0;
    endtask

    // Load 07:29:59; the 07:30:00 match is seen 4 cycles later and RING starts on the 5th.
    task automatic start_ring(input string name);
        do_load(24'h072959);
        repeat (5) tick();
        n_checks++;
        if (buzzer !== 1'b1 || ring_idx !== 2'd1)
            $display("FAIL %s_start: buzzer=%b ring_idx=%0d, want buzzer=1 ring_idx=1", name, buzzer, ring_idx);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if (bcd_time !== 24'h0 || sec_pulse !== 1'b0 || buzzer !== 1'b0 || ring_idx !== 2'd0 || alarm_armed !== 4'h0)
            $display("FAIL reset_outputs: time=%h pulse=%b buz=%b idx=%0d armed=%b, want all 0",
                     bcd_time, sec_pulse, buzzer, ring_idx, alarm_armed);
        else n_pass++;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (sec_pulse !== (i == 3))
                $display("FAIL first_pulse_cyc%0d: sec_pulse=%b want %b", i, sec_pulse, (i == 3));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (bcd_time !== 24'h000001) $display("FAIL first_second: time=%h want 000001", bcd_time);
        else n_pass++;
    endtask

    task automatic test_load_priority();
        repeat (3) tick();
        n_checks++;
        if (sec_pulse !== 1'b1) $display("FAIL prio_pulse_setup: sec_pulse=%b want 1", sec_pulse);
        else n_pass++;
        do_load(24'h101010);
        n_checks++;
        if (bcd_time !== 24'h101010 || sec_pulse !== 1'b0)
            $display("FAIL load_over_pulse: time=%h pulse=%b want 101010 pulse 0", bcd_time, sec_pulse);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (bcd_time !== 24'h101011) $display("FAIL after_load_tick: time=%h want 101011", bcd_time);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_load(24'h235958);
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (sec_pulse !== ((i % 4) == 3))
                $display("FAIL wrap_pulse_cyc%0d: sec_pulse=%b want %b", i, sec_pulse, ((i % 4) == 3));
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if (bcd_time !== 24'h235959) $display("FAIL wrap_mid: time=%h want 235959", bcd_time);
                else n_pass++;
            end
        end
        n_checks++;
        if (bcd_time !== 24'h000000) $display("FAIL wrap_midnight: time=%h want 000000", bcd_time);
        else n_pass++;
    endtask

    task automatic test_illegal_load();
        tick();
        do_load(24'h240000);
        n_checks++;
        if (bcd_time !== 24'h000000 || sec_pulse !== 1'b0)
            $display("FAIL illegal_hh: time=%h pulse=%b want 000000 pulse 0", bcd_time, sec_pulse);
        else n_pass++;
        do_load(24'h126A00);
        n_checks++;
        if (bcd_time !== 24'h000000 || sec_pulse !== 1'b1)
            $display("FAIL illegal_mm: time=%h pulse=%b want 000000 pulse 1", bcd_time, sec_pulse);
        else n_pass++;
        tick();
        n_checks++;
        if (bcd_time !== 24'h000001) $display("FAIL illegal_then_tick: time=%h want 000001", bcd_time);
        else n_pass++;
    endtask

    task automatic test_alarm_write();
        write_slot(2'd0, 16'h0730, 1'b0);
        write_slot(2'd1, 16'h0730, 1'b1);
        n_checks++;
        if (alarm_armed !== 4'b0010) $display("FAIL armed_slot1: armed=%b want 0010", alarm_armed);
        else n_pass++;
        write_slot(2'd3, 16'h0730, 1'b1);
        write_slot(2'd2, 16'h2400, 1'b1);
        write_slot(2'd2, 16'h0760, 1'b1);
        n_checks++;
        if (alarm_armed !== 4'b1010) $display("FAIL armed_illegal_ignored: armed=%b want 1010", alarm_armed);
        else n_pass++;
    endtask

    task automatic test_priority();
        int pulses;
        pulses = 0;
        start_ring("priority");
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (buzzer === 1'b1 && sec_pulse === 1'b1) pulses++;
            n_checks++;
            if (buzzer !== (k < 11)) $display("FAIL ring_len_cyc%0d: buzzer=%b want %b", k, buzzer, (k < 11));
            else n_pass++;
        end
        n_checks++;
        if (pulses != int'(RING_SECS)) $display("FAIL ring_pulses: saw %0d want %0d", pulses, RING_SECS);
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (buzzer !== 1'b0 || ring_idx !== 2'd1)
            $display("FAIL idle_hold: buzzer=%b ring_idx=%0d want 0 and 1", buzzer, ring_idx);
        else n_pass++;
    endtask

`ifdef CLOCK_SNOOZE_EN
    task automatic test_snooze();
        int seen_high;
        start_ring("snooze");
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        n_checks++;
        if (buzzer !== 1'b0) $display("FAIL snooze_enter: buzzer=%b want 0", buzzer);
        else n_pass++;
        for (int k = 1; k <= 18; k++) begin
            tick();
            n_checks++;
            if (buzzer !== (k == 18)) $display("FAIL snooze_len_cyc%0d: buzzer=%b want %b", k, buzzer, (k == 18));
            else n_pass++;
        end
        n_checks++;
        if (ring_idx !== 2'd1) $display("FAIL rering_idx: ring_idx=%0d want 1", ring_idx);
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if (buzzer !== (k < 12)) $display("FAIL rering_len_cyc%0d: buzzer=%b want %b", k, buzzer, (k < 12));
            else n_pass++;
        end
        start_ring("snooze_stop");
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        seen_high = 0;
        repeat (24) begin
            tick();
            if (buzzer !== 1'b0) seen_high++;
        end
        n_checks++;
        if (seen_high != 0) $display("FAIL stop_in_snooze: buzzer high %0d cycles, want 0", seen_high);
        else n_pass++;
    endtask
`else
    task automatic test_snooze_ignored();
        start_ring("no_snooze");
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        n_checks++;
        if (buzzer !== 1'b1) $display("FAIL snooze_ignored: buzzer=%b want 1", buzzer);
        else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (buzzer !== (k < 10)) $display("FAIL no_snooze_len_cyc%0d: buzzer=%b want %b", k, buzzer, (k < 10));
            else n_pass++;
        end
    endtask
`endif

    task automatic test_stop();
        int seen_high;
        start_ring("stop");
        stop   = 1'b1;
        snooze = 1'b1;
        tick();
        stop   = 1'b0;
        snooze = 1'b0;
        n_checks++;
        if (buzzer !== 1'b0) $display("FAIL stop_snooze_same: buzzer=%b want 0", buzzer);
        else n_pass++;
        seen_high = 0;
        repeat (24) begin
            tick();
            if (buzzer !== 1'b0) seen_high++;
        end
        n_checks++;
        if (seen_high != 0) $display("FAIL stop_stays_idle: buzzer high %0d cycles, want 0", seen_high);
        else n_pass++;
    endtask

    task automatic test_rewrite();
        start_ring("rewrite");
        write_slot(2'd2, 16'h0900, 1'b1);
        n_checks++;
        if (buzzer !== 1'b1 || alarm_armed !== 4'b1110)
            $display("FAIL other_slot_write: buzzer=%b armed=%b want 1 and 1110", buzzer, alarm_armed);
        else n_pass++;
        do_load(24'h080000);
        n_checks++;
        if (buzzer !== 1'b1 || bcd_time !== 24'h080000)
            $display("FAIL load_keeps_ring: buzzer=%b time=%h want 1 and 080000", buzzer, bcd_time);
        else n_pass++;
        write_slot(2'd1, 16'h0730, 1'b1);
        n_checks++;
        if (buzzer !== 1'b0) $display("FAIL ring_slot_rewrite: buzzer=%b want 0", buzzer);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ring();
        start_ring("reset");
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (buzzer !== 1'b0 || alarm_armed !== 4'h0 || bcd_time !== 24'h0 || ring_idx !== 2'd0)
            $display("FAIL async_reset: buz=%b armed=%b time=%h idx=%0d want all 0",
                     buzzer, alarm_armed, bcd_time, ring_idx);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (buzzer !== 1'b0) $display("FAIL after_reset: buzzer=%b want 0", buzzer);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_priority();
        test_wrap();
        test_illegal_load();
        test_alarm_write();
        test_priority();
`ifdef CLOCK_SNOOZE_EN
        test_snooze();
`else
        test_snooze_ignored();
`endif
        test_stop();
        test_rewrite();
        test_reset_mid_ring();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
